// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//
// Execute stage of a five-stage pipelined core.
//   * Operand forwarding: picks between the decode-stage register value, the
//     writeback result, and this stage's own registered ALU result.
//   * ALU: add, sub, and, or, xor, signed slt, sll and srl.
//   * Branch/jump resolution back to fetch (PCSrcE, PCTargetE).
//   * E/M pipeline register with synchronous active-high reset.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   RD1E, RD2E                  register operands from decode
//   PCE, ImmExtE, PCPlus4E      PC, extended immediate, PC+4 from decode
//   RdE                         destination register index
//   RegWriteE, MemWriteE,
//   JumpE, BranchE, ALUSrcE,
//   LoadByteE, ResultSrcE,
//   ALUControlE                 decode-stage control
//   ForwardAE, ForwardBE        hazard-unit forwarding selects
//   ResultW                     writeback result (forwarding source)
//   ALUResultM, WriteDataM,
//   PCPlus4M, RdM, RegWriteM,
//   MemWriteM, ResultSrcM,
//   LoadByteM                   registered E/M values
//   PCSrcE, PCTargetE           combinational redirect to fetch
// ---------------------------------------------------------------------------
module execute_stage #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [WORD_SIZE-1:0] RD1E,
  input  logic [WORD_SIZE-1:0] RD2E,
  input  logic [WORD_SIZE-1:0] PCE,
  input  logic [WORD_SIZE-1:0] ImmExtE,
  input  logic [WORD_SIZE-1:0] PCPlus4E,
  input  logic [4:0]           RdE,

  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 JumpE,
  input  logic                 BranchE,
  input  logic                 ALUSrcE,
  input  logic                 LoadByteE,
  input  logic [1:0]           ResultSrcE,
  input  logic [2:0]           ALUControlE,

  input  logic [1:0]           ForwardAE,
  input  logic [1:0]           ForwardBE,
  input  logic [WORD_SIZE-1:0] ResultW,

  output logic [WORD_SIZE-1:0] ALUResultM,
  output logic [WORD_SIZE-1:0] WriteDataM,
  output logic [WORD_SIZE-1:0] PCPlus4M,
  output logic [4:0]           RdM,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 LoadByteM,
  output logic [1:0]           ResultSrcM,

  output logic                 PCSrcE,
  output logic [WORD_SIZE-1:0] PCTargetE
);

  typedef enum logic [2:0] {
    aluAdd = 3'b000,
    aluSub = 3'b001,
    aluAnd = 3'b010,
    aluOr  = 3'b011,
    aluXor = 3'b100,
    aluSlt = 3'b101,
    aluSll = 3'b110,
    aluSrl = 3'b111
  } aluOp_t;

  logic [WORD_SIZE-1:0] SrcAE;
  logic [WORD_SIZE-1:0] SrcBE;
  logic [WORD_SIZE-1:0] WriteDataE;
  logic [WORD_SIZE-1:0] ALUResultE;
  logic [4:0]           shamt;
  logic                 ZeroE;

  // Forwarding select: 01 takes the writeback result, 10 takes this stage's
  // registered ALU result (the value captured at the previous edge), and
  // both 00 and the unused 11 fall back to the decode-stage register value.
  // Register indices are never looked at here; the hazard unit owns that.
  function automatic logic [WORD_SIZE-1:0] forwardMux(
    input logic [1:0]           sel,
    input logic [WORD_SIZE-1:0] regVal,
    input logic [WORD_SIZE-1:0] resultW,
    input logic [WORD_SIZE-1:0] aluResultM
  );
    case (sel)
      2'b01:   return resultW;
      2'b10:   return aluResultM;
      default: return regVal;
    endcase
  endfunction

  assign SrcAE      = forwardMux(ForwardAE, RD1E, ResultW, ALUResultM);
  assign WriteDataE = forwardMux(ForwardBE, RD2E, ResultW, ALUResultM);
  assign SrcBE      = ALUSrcE ? ImmExtE : WriteDataE;
  assign shamt      = SrcBE[4:0];

  // NOTE: every signal written in an always_comb gets a default on entry so
  // that no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    ALUResultE = '0;
    case (aluOp_t'(ALUControlE))
      aluAdd: ALUResultE = SrcAE + SrcBE;
      aluSub: ALUResultE = SrcAE - SrcBE;
      aluAnd: ALUResultE = SrcAE & SrcBE;
      aluOr:  ALUResultE = SrcAE | SrcBE;
      aluXor: ALUResultE = SrcAE ^ SrcBE;
      aluSlt: ALUResultE = {{(WORD_SIZE-1){1'b0}},
                            ($signed(SrcAE) < $signed(SrcBE))};
      aluSll: ALUResultE = SrcAE << shamt;
      aluSrl: ALUResultE = SrcAE >> shamt;
      default: ALUResultE = '0;
    endcase
  end

  assign ZeroE     = (ALUResultE == '0);
  assign PCTargetE = PCE + ImmExtE;

  // Redirect is suppressed for as long as reset is held, so fetch never
  // sees a stray jump from garbage decode outputs during reset.
  assign PCSrcE = ~rst & (JumpE | (BranchE & ZeroE));

  // E/M pipeline register: captures every edge, no stall or enable.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the edge; in particular the
  // forwarded ALUResultM above is always last cycle's value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      LoadByteM  <= 1'b0;
    end else begin
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      LoadByteM  <= LoadByteE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//
// Self-checking bench for execute_stage. A behavioural model tracks the E/M
// register contents and predicts the combinational redirect and the next
// registered values from the operand/forwarding/ALU rules. Directed cases
// cover the worked examples and reset behaviour; a randomized run follows.
// ---------------------------------------------------------------------------
module tb_execute_stage;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic [W-1:0]  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]    RdE;
  logic          RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, LoadByteE;
  logic [1:0]    ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]    ALUControlE;

  logic [W-1:0]  ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
  logic [4:0]    RdM;
  logic          RegWriteM, MemWriteM, LoadByteM, PCSrcE;
  logic [1:0]    ResultSrcM;

  execute_stage #(.WORD_SIZE(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .RD1E       (RD1E),
    .RD2E       (RD2E),
    .PCE        (PCE),
    .ImmExtE    (ImmExtE),
    .PCPlus4E   (PCPlus4E),
    .RdE        (RdE),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .JumpE      (JumpE),
    .BranchE    (BranchE),
    .ALUSrcE    (ALUSrcE),
    .LoadByteE  (LoadByteE),
    .ResultSrcE (ResultSrcE),
    .ALUControlE(ALUControlE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .ResultW    (ResultW),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .LoadByteM  (LoadByteM),
    .ResultSrcM (ResultSrcM),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Model of what the E/M register should currently hold.
  logic [W-1:0] mAlu, mWd, mPc4;
  logic [4:0]   mRd;
  logic         mRegW, mMemW, mLb;
  logic [1:0]   mResSrc;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] pickOperand(input logic [1:0] sel,
                                               input logic [W-1:0] regVal);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return mAlu;
    return regVal;
  endfunction

  // ALU written from the arithmetic meaning of each operation.
  function automatic logic [W-1:0] aluModel(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned pow = 64'd1 << (b % 32);
    longint          sa = int'(a);
    longint          sb = int'(b);
    case (op)
      3'd0: return W'((ua + ub) % (64'd1 << W));
      3'd1: return W'((ua + (64'd1 << W) - ub) % (64'd1 << W));
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? W'(1) : W'(0);
      3'd6: return W'((ua * pow) % (64'd1 << W));
      default: return W'(ua / pow);
    endcase
  endfunction

  // One pipeline cycle: check the combinational redirect with the inputs
  // currently applied, clock once, then check the registered outputs.
  task automatic doCycle();
    logic [W-1:0] a, wd, b, res;
    logic         expPcSrc;
    #2;
    a   = pickOperand(ForwardAE, RD1E);
    wd  = pickOperand(ForwardBE, RD2E);
    b   = ALUSrcE ? ImmExtE : wd;
    res = aluModel(ALUControlE, a, b);
    expPcSrc = !rst && (JumpE || (BranchE && res == 0));
    check("PCSrcE", 64'(PCSrcE), 64'(expPcSrc));
    check("PCTargetE", 64'(PCTargetE), 64'(W'((64'(PCE) + 64'(ImmExtE)) % (64'd1 << W))));
    @(posedge clk);
    #1;
    if (rst) begin
      mAlu = '0; mWd = '0; mPc4 = '0; mRd = '0;
      mRegW = 0; mMemW = 0; mLb = 0; mResSrc = '0;
    end else begin
      mAlu = res; mWd = wd; mPc4 = PCPlus4E; mRd = RdE;
      mRegW = RegWriteE; mMemW = MemWriteE; mLb = LoadByteE; mResSrc = ResultSrcE;
    end
    check("ALUResultM", 64'(ALUResultM), 64'(mAlu));
    check("WriteDataM", 64'(WriteDataM), 64'(mWd));
    check("PCPlus4M",   64'(PCPlus4M),   64'(mPc4));
    check("RdM",        64'(RdM),        64'(mRd));
    check("RegWriteM",  64'(RegWriteM),  64'(mRegW));
    check("MemWriteM",  64'(MemWriteM),  64'(mMemW));
    check("LoadByteM",  64'(LoadByteM),  64'(mLb));
    check("ResultSrcM", 64'(ResultSrcM), 64'(mResSrc));
  endtask

  task automatic clearInputs();
    RD1E = '0; RD2E = '0; PCE = '0; ImmExtE = '0; PCPlus4E = '0; ResultW = '0;
    RdE = '0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
    ALUSrcE = 0; LoadByteE = 0; ResultSrcE = '0; ALUControlE = '0;
    ForwardAE = '0; ForwardBE = '0;
  endtask

  task automatic aluOp(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    clearInputs();
    ALUControlE = op; RD1E = a; RD2E = b; RegWriteE = 1; RdE = 5'd1;
  endtask

  initial begin
    mAlu = '0; mWd = '0; mPc4 = '0; mRd = '0;
    mRegW = 0; mMemW = 0; mLb = 0; mResSrc = '0;
    clearInputs();
    rst = 1;
    doCycle();
    doCycle();
    check("reset ALUResultM", 64'(ALUResultM), 64'd0);
    check("reset RegWriteM",  64'(RegWriteM),  64'd0);
    rst = 0;

    // Basic add into the E/M register.
    clearInputs();
    RD1E = 5; RD2E = 7; RegWriteE = 1; RdE = 3;
    doCycle();
    check("add ALUResultM", 64'(ALUResultM), 64'd12);
    check("add WriteDataM", 64'(WriteDataM), 64'd7);
    check("add RdM",        64'(RdM),        64'd3);
    check("add RegWriteM",  64'(RegWriteM),  64'd1);

    // Forwarding from ALUResultM, then from ResultW.
    aluOp(3'd0, 32'h8, 32'h8);
    doCycle();
    check("fwd setup", 64'(ALUResultM), 64'h10);
    clearInputs();
    ForwardAE = 2'b10; ImmExtE = 4; ALUSrcE = 1; RD1E = 32'hDEAD;
    doCycle();
    check("fwd from M", 64'(ALUResultM), 64'h14);
    ForwardAE = 2'b01; ResultW = 32'h100;
    doCycle();
    check("fwd from W", 64'(ALUResultM), 64'h104);

    // Branch resolution.
    clearInputs();
    BranchE = 1; ALUControlE = 3'd1; RD1E = 9; RD2E = 9; PCE = 32'h40;
    ImmExtE = 32'hFFFF_FFF8;
    #2;
    check("beq taken PCSrcE", 64'(PCSrcE), 64'd1);
    check("beq PCTargetE",    64'(PCTargetE), 64'h38);
    doCycle();
    RD2E = 8;
    #2;
    check("beq not taken PCSrcE", 64'(PCSrcE), 64'd0);
    doCycle();

    // ALU corner cases.
    aluOp(3'd5, 32'hFFFF_FFFF, 32'd1);
    doCycle();
    check("slt signed", 64'(ALUResultM), 64'd1);
    aluOp(3'd0, 32'hFFFF_FFFF, 32'd1);
    doCycle();
    check("add wrap", 64'(ALUResultM), 64'd0);
    aluOp(3'd6, 32'd1, 32'd33);
    doCycle();
    check("sll by 33", 64'(ALUResultM), 64'd2);

    // Jump during reset discards in-flight contents.
    aluOp(3'd0, 32'h11, 32'h22);
    MemWriteE = 1; LoadByteE = 1; ResultSrcE = 2'b10; PCPlus4E = 32'h44;
    doCycle();
    clearInputs();
    JumpE = 1; rst = 1; RegWriteE = 1; RD1E = 3;
    #2;
    check("jump in reset PCSrcE", 64'(PCSrcE), 64'd0);
    doCycle();
    check("reset clears ALUResultM", 64'(ALUResultM), 64'd0);
    check("reset clears MemWriteM",  64'(MemWriteM),  64'd0);
    check("reset clears PCPlus4M",   64'(PCPlus4M),   64'd0);
    rst = 0;
    #1;
    check("jump after reset PCSrcE", 64'(PCSrcE), 64'd1);
    doCycle();
    check("first after reset RegWriteM", 64'(RegWriteM), 64'd1);

    // Store data forwarded from ALUResultM.
    aluOp(3'd0, 32'hA0, 32'h0B);
    doCycle();
    clearInputs();
    MemWriteE = 1; ForwardBE = 2'b10; RD2E = 32'h5555;
    doCycle();
    check("store fwd WriteDataM", 64'(WriteDataM), 64'hAB);
    check("store fwd MemWriteM",  64'(MemWriteM),  64'd1);

    // Bubble.
    clearInputs();
    doCycle();
    check("bubble RegWriteM", 64'(RegWriteM), 64'd0);

    // Randomized stream against the model.
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 24) == 0);
      RD1E        = $urandom;
      RD2E        = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
      PCE         = $urandom;
      ImmExtE     = ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 40));
      PCPlus4E    = $urandom;
      ResultW     = $urandom;
      RdE         = 5'($urandom);
      RegWriteE   = 1'($urandom);
      MemWriteE   = 1'($urandom);
      JumpE       = ($urandom_range(0, 7) == 0);
      BranchE     = 1'($urandom);
      ALUSrcE     = 1'($urandom);
      LoadByteE   = 1'($urandom);
      ResultSrcE  = 2'($urandom);
      ALUControlE = 3'($urandom);
      ForwardAE   = 2'($urandom);
      ForwardBE   = 2'($urandom);
      doCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data-path width (the codebase-wide word size).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports RD1E, RD2E, PCE, ImmExtE, PCPlus4E  input  WORD_SIZE  decode-stage operands, PC, extended immediate, PC+4.
REQ-005 SHALL have port RdE  input  5  destination register from decode.
REQ-006 SHALL have ports RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, LoadByteE  input  1  decode-stage control.
REQ-007 SHALL have ports ResultSrcE  input  2  and ALUControlE  input  3  (decode-stage control).
REQ-008 SHALL have ports ForwardAE, ForwardBE  input  2  hazard-unit forwarding selects.
REQ-009 SHALL have port ResultW  input  WORD_SIZE  writeback result, forwarding source.
REQ-010 SHALL have ports ALUResultM, WriteDataM, PCPlus4M  output  WORD_SIZE  registered E/M values.
REQ-011 SHALL have port RdM  output  5  and ports RegWriteM, MemWriteM, LoadByteM  output  1, and ResultSrcM  output  2  (registered).
REQ-012 SHALL have ports PCSrcE  output  1  and PCTargetE  output  WORD_SIZE  (combinational branch resolution to fetch).

Function
REQ-013 SHALL select SrcAE by ForwardAE: 00 RD1E, 01 ResultW, 10 ALUResultM (the stage's own registered output), 11 treated as 00.
REQ-014 SHALL select WriteDataE by ForwardBE with the same encoding applied to RD2E.
REQ-015 SHALL drive SrcBE = ImmExtE when ALUSrcE=1, else WriteDataE.
REQ-016 SHALL compute ALUResultE by ALUControlE: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, result 1/0 zero-extended), 110 sll by SrcBE[4:0], 111 srl by SrcBE[4:0].
REQ-017 SHALL wrap add/sub modulo 2^WORD_SIZE, with no overflow flag.
REQ-018 SHALL set ZeroE=1 exactly when ALUResultE is all-zero.
REQ-019 SHALL drive PCTargetE = PCE + ImmExtE, modulo 2^WORD_SIZE.
REQ-020 SHALL drive PCSrcE = ~rst & (JumpE | (BranchE & ZeroE)).
REQ-021 SHALL capture every rising edge with rst=0, with no stall or enable (one-cycle E->M latency): ALUResultM<=ALUResultE, WriteDataM<=WriteDataE, PCPlus4M<=PCPlus4E, RdM<=RdE, RegWriteM<=RegWriteE, MemWriteM<=MemWriteE, ResultSrcM<=ResultSrcE, LoadByteM<=LoadByteE.
REQ-022 SHALL NOT inspect register indices; forwarding correctness, including x0, is the hazard unit's responsibility.
REQ-023 SHALL register a bubble from decode (all controls 0) as a bubble: RegWriteM=MemWriteM=0.
REQ-024 SHALL, when forwarding from ALUResultM, use the value registered at the previous edge, never the value being captured at the current edge.

Reset
REQ-025 SHALL, on a rising edge with rst=1, clear all M outputs to 0 (ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM, LoadByteM).
REQ-026 SHALL hold PCSrcE=0 for the whole time rst=1, regardless of JumpE and BranchE.
REQ-027 SHALL let a reset asserted mid-stream discard the in-flight E/M contents, and SHALL capture the first instruction after rst deasserts normally on the next edge.

Verification
REQ-028 SHALL be verified by: RD1E=5, RD2E=7, ALUSrcE=0, ALUControlE=000, ForwardAE=ForwardBE=00, RegWriteE=1, RdE=3 -> after one edge ALUResultM=12, WriteDataM=7, RdM=3, RegWriteM=1.
REQ-029 SHALL be verified by: cycle N add giving ALUResultM=0x10; cycle N+1 ForwardAE=10, ImmExtE=4, ALUSrcE=1, add -> ALUResultM=0x14; repeat with ForwardAE=01, ResultW=0x100 -> 0x104.
REQ-030 SHALL be verified by: BranchE=1, ALUControlE=001, RD1E=RD2E=9, PCE=0x40, ImmExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0x38; with RD2E=8 -> PCSrcE=0.
REQ-031 SHALL be verified by: slt with SrcA=0xFFFFFFFF, SrcB=1 -> ALUResultM=1; add 0xFFFFFFFF+1 -> ALUResultM=0; sll 1 by 33 -> ALUResultM=2.
REQ-032 SHALL be verified by: JumpE=1 with rst=1 -> PCSrcE=0, all M outputs 0 after the edge; rst deasserted -> PCSrcE=1 immediately.
REQ-033 SHALL be verified by: MemWriteE=1, ForwardBE=10, ALUResultM=0xAB -> WriteDataM=0xAB, MemWriteM=1 after one edge.
